hm2reg_io_pipe: RTL
===================

Name: hm2reg_io_pipe

Overview:
Parametrised Avalon-MM slave bridge between the HPS lightweight bus and the HostMot2 register bus. Successor to the single-cycle pass-through bridge, adding:
- waitrequest flow control;
- a programmable HostMot2 read latency;
- a local CSR window;
- multi-channel interrupt aggregation with mask, edge/level mode and write-1-to-clear status.

It sits between the HPS-to-FPGA interconnect and the hm2 top-level register file.

Parameters:
ADDRESS_WIDTH, 14, con-side word address width; slave_address is one bit wider.
DATA_WIDTH, 32, data word width; must be >= 32.
READ_LATENCY, 2, cycles from con_read_out high to con_datain valid; legal range 1..15.
IRQ_CHANNELS, 4, number of active-low interrupt inputs; legal range 1..DATA_WIDTH.
IRQ_EN, 1, 1 = slave_irq driven; 0 = slave_irq tied 0 (status logic still runs).
IRQ_MASK_INIT, 1, reset value of the IRQ_MASK register.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
slave_address  in  ADDRESS_WIDTH+1  word address; MSB=1 selects the local CSR window
slave_chipselect  in  1  Avalon chip select
slave_read  in  1  read request
slave_write  in  1  write request
slave_writedata  in  DATA_WIDTH  write data
slave_readdata  out  DATA_WIDTH  read data, valid when waitrequest is low
slave_waitrequest  out  1  stall
slave_irq  out  1  aggregated interrupt, active high
con_adrout  out  ADDRESS_WIDTH  hm2 address
con_dataout  out  DATA_WIDTH  hm2 write data
con_datain  in  DATA_WIDTH  hm2 read data
con_write_out  out  1  hm2 write strobe, one cycle
con_read_out  out  1  hm2 read strobe, one cycle
con_chip_sel  out  1  hm2 chip select, high from the strobe cycle until the access completes
con_int_in  in  IRQ_CHANNELS  interrupt sources, active low, asynchronous

Behaviour:
- Reset (async, any time, including mid-transaction):
  - FSM goes to IDLE.
  - All outputs are 0, except slave_waitrequest (combinational; see below).
  - IRQ_STATUS = 0, IRQ_MODE = 0 (all level), IRQ_MASK = IRQ_MASK_INIT.
  - Synchronisers are cleared to 1 (inactive).
  - After release, no stale strobe or irq is emitted.
- Request definition: req = slave_chipselect & (slave_read | slave_write). If read and write are both high, the access is treated as a read.
- slave_waitrequest = req & (state != DONE), combinational.
- FSM states: IDLE, WR, RD, DONE.
- IDLE, con-window write:
  - Register con_adrout, con_dataout; set con_write_out=1 and con_chip_sel=1.
  - Go to WR.
- WR: con_write_out drops to 0; go to DONE.
  - Write costs 2 wait states.
- IDLE, con-window read:
  - Register con_adrout; set con_read_out=1 and con_chip_sel=1.
  - Load cnt = READ_LATENCY; go to RD.
- RD:
  - con_read_out = 0; decrement cnt each cycle.
  - On the cycle cnt==1, capture slave_readdata <= con_datain (READ_LATENCY cycles after the strobe cycle); go to DONE.
  - Read costs READ_LATENCY+1 wait states.
- IDLE, CSR-window access (address MSB=1):
  - Decoded on slave_address[1:0]; no con strobe and con_chip_sel stays 0.
  - Write updates the register; read loads slave_readdata.
  - Go directly to DONE (1 wait state).
- DONE:
  - waitrequest low; con_chip_sel drops to 0.
  - Return to IDLE next cycle regardless of req, so back-to-back transfers are not merged.
- con_dataout and con_adrout hold their last values between accesses.
- CSR map (word offsets), zero-extended to DATA_WIDTH:
  - 0 IRQ_STATUS:
    - Read gives the pending bits.
    - Write-1-to-clear applies only to edge-mode bits.
    - Level-mode bits mirror the synchronised input (1 while input low); writes to them are ignored.
  - 1 IRQ_MASK: R/W, 1 = enabled.
  - 2 IRQ_MODE: R/W, per bit 0 = level, 1 = falling-edge.
  - 3 ID: read-only {16'h4832, 4'h0, READ_LATENCY[3:0], 8'(IRQ_CHANNELS)}; writes ignored.
- Interrupts:
  - Each con_int_in bit passes through a 2-flop synchroniser.
  - Edge mode: status bit is set in the cycle after a synchronised 1->0 transition.
  - Set and W1C in the same cycle: set wins.
  - Changing a bit's mode clears that bit's status.
  - slave_irq is registered: IRQ_EN & |(IRQ_STATUS & IRQ_MASK), one cycle after status changes.
- Unused bits of CSR registers above IRQ_CHANNELS read 0.

Test Plan:
- Reset: assert reset mid-RD with READ_LATENCY=2 -> all con_* outputs 0 immediately, FSM IDLE; after release a fresh read of addr 0x0010 completes normally.
- Con write: write 0xDEADBEEF to 0x0123 -> con_write_out high exactly 1 cycle with con_adrout=0x123, con_dataout=0xDEADBEEF; waitrequest high for 2 cycles.
- Con read, READ_LATENCY=3: con_datain=0xCAFEF00D driven 3 cycles after con_read_out -> slave_readdata=0xCAFEF00D; waitrequest high for 4 cycles; one con_read_out pulse only.
- CSR read: read CSR 3 with defaults -> 0x48320204; no con strobe or con_chip_sel activity.
- Edge IRQ: MODE=0x1, MASK=0x1; pulse con_int_in[0] low 1 cycle -> STATUS=0x1 and slave_irq=1 within 4 cycles; W1C 0x1 coincident with a new falling edge -> status stays 1.
- Level IRQ/mask: con_int_in[2] held low, MASK=0x1 -> STATUS bit2=1, slave_irq=0; write MASK=0x4 -> slave_irq=1; release input -> status and irq clear; with IRQ_EN=0, slave_irq stays 0 throughout.

Source files
------------

// File: rtl/hm2reg_io_pipe.sv
// hm2reg_io_pipe: Avalon-MM slave bridge from the HPS lightweight bus to the
// HostMot2 register bus. Adds waitrequest flow control, a programmable hm2
// read latency, a local CSR window (address MSB = 1) and an interrupt block
// with per-channel mask, level/falling-edge mode and write-1-to-clear status.

module hm2reg_io_pipe #(
    parameter int                    ADDRESS_WIDTH = 14,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    READ_LATENCY  = 2,
    parameter int                    IRQ_CHANNELS  = 4,
    parameter bit                    IRQ_EN        = 1'b1,
    parameter logic [DATA_WIDTH-1:0] IRQ_MASK_INIT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH:0]   slave_address,
    input  logic                     slave_chipselect,
    input  logic                     slave_read,
    input  logic                     slave_write,
    input  logic [DATA_WIDTH-1:0]    slave_writedata,
    output logic [DATA_WIDTH-1:0]    slave_readdata,
    output logic                     slave_waitrequest,
    output logic                     slave_irq,
    output logic [ADDRESS_WIDTH-1:0] con_adrout,
    output logic [DATA_WIDTH-1:0]    con_dataout,
    input  logic [DATA_WIDTH-1:0]    con_datain,
    output logic                     con_write_out,
    output logic                     con_read_out,
    output logic                     con_chip_sel,
    input  logic [IRQ_CHANNELS-1:0]  con_int_in
);

    // Transfer FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR   = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // CSR word offsets
    localparam logic [1:0] CSR_STATUS = 2'd0;
    localparam logic [1:0] CSR_MASK   = 2'd1;
    localparam logic [1:0] CSR_MODE   = 2'd2;
    localparam logic [1:0] CSR_ID     = 2'd3;

    localparam logic [3:0]  RD_LAT  = 4'(READ_LATENCY);
    localparam logic [31:0] ID_WORD = {16'h4832, 4'h0, 4'(READ_LATENCY), 8'(IRQ_CHANNELS)};

    logic [1:0]               state;
    logic [3:0]               cnt;

    logic                     req;
    logic                     is_rd;
    logic                     is_csr;
    logic                     csr_we;
    logic [1:0]               csr_off;
    logic [ADDRESS_WIDTH-1:0] con_addr;
    logic [DATA_WIDTH-1:0]    csr_rdata;

    logic [IRQ_CHANNELS-1:0]  sync1;
    logic [IRQ_CHANNELS-1:0]  sync2;
    logic [IRQ_CHANNELS-1:0]  sync_d;
    logic [IRQ_CHANNELS-1:0]  irq_status;
    logic [IRQ_CHANNELS-1:0]  irq_mask;
    logic [IRQ_CHANNELS-1:0]  irq_mode;

    logic [IRQ_CHANNELS-1:0]  csr_wval;
    logic [IRQ_CHANNELS-1:0]  fall;
    logic [IRQ_CHANNELS-1:0]  w1c;
    logic [IRQ_CHANNELS-1:0]  mode_chg;
    logic [IRQ_CHANNELS-1:0]  status_nxt;

    // Zero-extend a per-channel register to the bus width
    function automatic logic [DATA_WIDTH-1:0] zext_ch(input logic [IRQ_CHANNELS-1:0] v);
        zext_ch = DATA_WIDTH'(v);
    endfunction

    // Request decode; a simultaneous read+write is handled as a read
    always_comb begin
        req               = slave_chipselect & (slave_read | slave_write);
        is_rd             = slave_read;
        is_csr            = slave_address[ADDRESS_WIDTH];
        csr_off           = slave_address[1:0];
        con_addr          = slave_address[ADDRESS_WIDTH-1:0];
        csr_we            = req & (state == IDLE) & is_csr & ~is_rd;
        csr_wval          = slave_writedata[IRQ_CHANNELS-1:0];
        slave_waitrequest = req & (state != DONE);
    end

    // CSR read mux
    always_comb begin
        csr_rdata = '0;
        case (csr_off)
            CSR_STATUS: csr_rdata = zext_ch(irq_status);
            CSR_MASK:   csr_rdata = zext_ch(irq_mask);
            CSR_MODE:   csr_rdata = zext_ch(irq_mode);
            CSR_ID:     csr_rdata = DATA_WIDTH'(ID_WORD);
            default:    csr_rdata = '0;
        endcase
    end

    // Next interrupt status: edge bits are sticky with W1C (a new edge beats
    // the clear), level bits follow the synchronised input, and a mode
    // change zeroes the affected bits so no stale state crosses modes
    always_comb begin
        fall       = sync_d & ~sync2;
        w1c        = (csr_we && csr_off == CSR_STATUS) ? csr_wval : '0;
        mode_chg   = (csr_we && csr_off == CSR_MODE) ? (irq_mode ^ csr_wval) : '0;
        status_nxt = ((irq_mode & ((irq_status & ~w1c) | fall)) | (~irq_mode & ~sync2))
                     & ~mode_chg;
    end

    // Transfer FSM: strobes, address/data capture and read-data return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            con_adrout     <= '0;
            con_dataout    <= '0;
            con_write_out  <= 1'b0;
            con_read_out   <= 1'b0;
            con_chip_sel   <= 1'b0;
            slave_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (is_csr) begin
                            if (is_rd) begin
                                slave_readdata <= csr_rdata;
                            end
                            state <= DONE;
                        end else if (is_rd) begin
                            con_adrout   <= con_addr;
                            con_read_out <= 1'b1;
                            con_chip_sel <= 1'b1;
                            cnt          <= RD_LAT;
                            state        <= RD;
                        end else begin
                            con_adrout    <= con_addr;
                            con_dataout   <= slave_writedata;
                            con_write_out <= 1'b1;
                            con_chip_sel  <= 1'b1;
                            state         <= WR;
                        end
                    end
                end
                WR: begin
                    con_write_out <= 1'b0;
                    con_chip_sel  <= 1'b0;
                    state         <= DONE;
                end
                RD: begin
                    con_read_out <= 1'b0;
                    cnt          <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        slave_readdata <= con_datain;
                        con_chip_sel   <= 1'b0;
                        state          <= DONE;
                    end
                end
                default: begin
                    // DONE: one cycle with waitrequest low, then always back
                    // to IDLE so consecutive transfers stay separate
                    con_chip_sel <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Interrupt synchronisers, CSR registers and registered irq output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= '1;
            sync2      <= '1;
            sync_d     <= '1;
            irq_status <= '0;
            irq_mode   <= '0;
            irq_mask   <= IRQ_MASK_INIT[IRQ_CHANNELS-1:0];
            slave_irq  <= 1'b0;
        end else begin
            sync1      <= con_int_in;
            sync2      <= sync1;
            sync_d     <= sync2;
            irq_status <= status_nxt;
            if (csr_we && csr_off == CSR_MASK) begin
                irq_mask <= csr_wval;
            end
            if (csr_we && csr_off == CSR_MODE) begin
                irq_mode <= csr_wval;
            end
            slave_irq <= IRQ_EN & (|(irq_status & irq_mask));
        end
    end

endmodule
